// File: rtl/oe_sorter_if.sv
// Stream bundle for oe_sorter: packet input (snk) and sorted packet output (src).
// The slave modport is the sorter's view; master is the view of the surrounding datapath.
interface oe_sorter_if #(
    parameter int unsigned DWIDTH = 8
);
    logic [DWIDTH-1:0] snk_data_i;
    logic              snk_valid_i;
    logic              snk_sop_i;
    logic              snk_eop_i;
    logic              snk_ready_o;
    logic [DWIDTH-1:0] src_data_o;
    logic              src_valid_o;
    logic              src_sop_o;
    logic              src_eop_o;
    logic              src_ready_i;

    modport slave (
        input  snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, src_ready_i,
        output snk_ready_o, src_data_o, src_valid_o, src_sop_o, src_eop_o
    );

    modport master (
        output snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, src_ready_i,
        input  snk_ready_o, src_data_o, src_valid_o, src_sop_o, src_eop_o
    );
endinterface

// File: rtl/oe_sorter.sv
// Packet sorter: buffers up to MAX_PKT_LEN words, sorts them with an odd-even
// transposition network (one pass per cycle) and streams them back with sop/eop framing.
module oe_sorter #(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned MAX_PKT_LEN = 16
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       clear_i,
    input  logic       desc_i,
    oe_sorter_if.slave bus,
    output logic       overflow_o
);
    localparam int unsigned LWIDTH = $clog2(MAX_PKT_LEN + 1);
    localparam logic [LWIDTH-1:0] LenMax = LWIDTH'(MAX_PKT_LEN);
    localparam logic [LWIDTH-1:0] LenOne = LWIDTH'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StSort, StOut} state_e;

    state_e              r_state;
    logic [LWIDTH-1:0]   r_len;
    logic [LWIDTH-1:0]   r_pass;
    logic [LWIDTH-1:0]   r_rd_idx;
    logic                r_desc;
    logic                r_ovf_seen;
    logic                r_overflow;
    logic                r_ready;
    logic                r_valid;
    logic                r_sop;
    logic                r_eop;
    logic [DWIDTH-1:0]   r_data;
    logic [DWIDTH-1:0]   r_mem [MAX_PKT_LEN];

    logic                w_accept;
    logic                w_wr_en;
    logic [LWIDTH-1:0]   w_wr_idx;
    logic                w_odd_pass;
    logic [DWIDTH-1:0]   w_sorted [MAX_PKT_LEN];
    logic [DWIDTH-1:0]   w_next_data;

    assign w_accept   = bus.snk_valid_i & r_ready;
    assign w_odd_pass = r_pass[0];
    // Sop always restarts at slot 0; words past the storage depth are never written.
    assign w_wr_en    = !clear_i && w_accept &&
                        (bus.snk_sop_i || (r_state == StLoad && r_len < LenMax));
    assign w_wr_idx   = bus.snk_sop_i ? '0 : r_len;

    // Pairs in one pass are disjoint, so every swap reads the pre-pass contents.
    always_comb begin
        w_sorted = r_mem;
        for (int i = 0; i < int'(MAX_PKT_LEN) - 1; i++) begin
            if ((((i % 2) == 1) == w_odd_pass) && (LWIDTH'(i + 1) < r_len)) begin
                if (r_desc ? (r_mem[i] < r_mem[i+1]) : (r_mem[i] > r_mem[i+1])) begin
                    w_sorted[i]   = r_mem[i+1];
                    w_sorted[i+1] = r_mem[i];
                end
            end
        end
    end

    always_comb begin
        w_next_data = '0;
        for (int i = 0; i < int'(MAX_PKT_LEN); i++) begin
            if (LWIDTH'(i) == r_rd_idx + LenOne) begin
                w_next_data = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clear_i && r_state == StSort) begin
            r_mem <= w_sorted;
        end else if (w_wr_en) begin
            for (int i = 0; i < int'(MAX_PKT_LEN); i++) begin
                if (LWIDTH'(i) == w_wr_idx) begin
                    r_mem[i] <= bus.snk_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state    <= StIdle;
            r_len      <= '0;
            r_pass     <= '0;
            r_rd_idx   <= '0;
            r_desc     <= 1'b0;
            r_ovf_seen <= 1'b0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_data     <= '0;
        end else begin
            r_overflow <= 1'b0;
            if (clear_i) begin
                r_state    <= StIdle;
                r_len      <= '0;
                r_pass     <= '0;
                r_rd_idx   <= '0;
                r_ovf_seen <= 1'b0;
                r_ready    <= 1'b1;
                r_valid    <= 1'b0;
                r_sop      <= 1'b0;
                r_eop      <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_accept && bus.snk_sop_i) begin
                            r_len      <= LenOne;
                            r_desc     <= desc_i;
                            r_ovf_seen <= 1'b0;
                            if (bus.snk_eop_i) begin
                                r_state <= StSort;
                                r_ready <= 1'b0;
                                r_pass  <= '0;
                            end else begin
                                r_state <= StLoad;
                            end
                        end
                    end
                    StLoad: begin
                        if (w_accept) begin
                            if (bus.snk_sop_i) begin
                                r_len      <= LenOne;
                                r_desc     <= desc_i;
                                r_ovf_seen <= 1'b0;
                            end else if (r_len < LenMax) begin
                                r_len <= r_len + LenOne;
                            end else if (!r_ovf_seen) begin
                                r_overflow <= 1'b1;
                                r_ovf_seen <= 1'b1;
                            end
                            if (bus.snk_eop_i) begin
                                r_state <= StSort;
                                r_ready <= 1'b0;
                                r_pass  <= '0;
                            end
                        end
                    end
                    StSort: begin
                        r_pass <= r_pass + LenOne;
                        if (r_pass == r_len - LenOne) begin
                            r_state  <= StOut;
                            r_rd_idx <= '0;
                            r_valid  <= 1'b1;
                            r_sop    <= 1'b1;
                            r_eop    <= (r_len == LenOne);
                            r_data   <= w_sorted[0];
                        end
                    end
                    StOut: begin
                        if (bus.src_ready_i) begin
                            if (r_rd_idx == r_len - LenOne) begin
                                r_state  <= StIdle;
                                r_rd_idx <= '0;
                                r_valid  <= 1'b0;
                                r_sop    <= 1'b0;
                                r_eop    <= 1'b0;
                                r_ready  <= 1'b1;
                            end else begin
                                r_rd_idx <= r_rd_idx + LenOne;
                                r_sop    <= 1'b0;
                                r_eop    <= (r_rd_idx + LWIDTH'(2) == r_len);
                                r_data   <= w_next_data;
                            end
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.snk_ready_o = r_ready;
    assign bus.src_valid_o = r_valid;
    assign bus.src_sop_o   = r_sop;
    assign bus.src_eop_o   = r_eop;
    assign bus.src_data_o  = r_data;
    assign overflow_o      = r_overflow;
endmodule
